// File: rtl/key_sched_pkg.sv
// Shared definitions for the keypad scheduler.
// - Key index constants for the five-way navigation pad.
// - Output FSM state type.
package calc_key_pkg;

  localparam int KEY_CENTER = 0;
  localparam int KEY_UP     = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_LEFT   = 3;
  localparam int KEY_RIGHT  = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_e;

endpackage

// File: rtl/key_sched_if.sv
// Key-event handshake bundle between the keypad scheduler and the core.
// - key_valid : event offered (scheduler -> core)
// - key_code  : index of the offered key (scheduler -> core)
// - key_ready : core accepts the offered event (core -> scheduler)
interface key_sched_if #(
  parameter int N_KEYS = 5
) ();
  localparam int CW = $clog2(N_KEYS);

  logic          key_valid;
  logic          key_ready;
  logic [CW-1:0] key_code;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/key_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and a
// registered rising-edge flag.
// Ports:
// - clk, rst_n : clock, asynchronous active-low reset
// - btn        : raw asynchronous button level
// - db         : debounced level
// - rise       : one-cycle flag, high in the cycle db has just gone high
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized sample disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = db_d & ~db_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
endmodule

// File: rtl/key_sched.sv
// Keypad scheduler: debounces N_KEYS buttons, queues one pending press per
// key and offers presses one at a time, round-robin, over valid/ready.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat of a single held key).
// Ports:
// - clk, rst_n : clock, asynchronous active-low reset
// - btn_in     : raw button levels, active-high
// - kbus       : key_valid / key_code / key_ready handshake (master side)
// - pending    : per-key queued-press flags
// - overrun    : one-cycle pulse when a press merges into a pending one
module key_sched
  import calc_key_pkg::*;
#(
  parameter int N_KEYS       = 5,
  parameter int DEB_CYCLES   = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 20000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] btn_in,
  key_sched_if.master       kbus,
  output logic [N_KEYS-1:0] pending,
  output logic              overrun
);
  localparam int CW = $clog2(N_KEYS);

  if (N_KEYS < 2) begin : g_bad_nkeys
    $error("key_sched: N_KEYS must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("key_sched: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  logic [N_KEYS-1:0] db_vec, rise_vec, rep_set, set_vec, clr_vec;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic              overrun_q, overrun_d;
  state_e            state_q, state_d;
  logic [CW-1:0]     code_q, code_d, rr_q, rr_d;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_in[i]),
      .db   (db_vec[i]),
      .rise (rise_vec[i])
    );
  end

  // First requesting key at or after ptr, searching upward with wrap.
  function automatic logic [CW-1:0] rr_pick(input logic [N_KEYS-1:0] req,
                                            input logic [CW-1:0] ptr);
    logic [CW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_KEYS; k++) begin
      idx = (int'(ptr) + k) % N_KEYS;
      if (!found && req[idx]) begin
        pick  = CW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    return (v == CW'(N_KEYS - 1)) ? '0 : v + CW'(1);
  endfunction

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [N_KEYS-1:0] db_prev_q;
  logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
  logic              rep_first_q, rep_first_d;
  logic              one_hot;

  // Counts only while the same single key stays held; any change of the
  // debounced vector (press, release, second key) restarts the delay.
  always_comb begin
    one_hot     = (db_vec != '0) && ((db_vec & (db_vec - N_KEYS'(1))) == '0);
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    rep_set     = '0;
    if (db_vec == db_prev_q && one_hot) begin
      rep_first_d = rep_first_q;
      if (rep_first_q ? (rep_cnt_q == RW'(REPEAT_DELAY - 1))
                      : (rep_cnt_q == RW'(REPEAT_RATE - 1))) begin
        rep_set     = db_vec;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_q   <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      db_prev_q   <= db_vec;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_set = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pending_q != '0) state_d = S_VALID;
      S_VALID: if (kbus.key_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: grant, pending update, overrun
  always_comb begin
    code_d  = code_q;
    rr_d    = rr_q;
    clr_vec = '0;
    if (state_q == S_IDLE && pending_q != '0) begin
      code_d = rr_pick(pending_q, rr_q);
    end
    if (state_q == S_VALID && kbus.key_ready) begin
      clr_vec = N_KEYS'(1) << code_q;
      rr_d    = wrap_inc(code_q);
    end
    set_vec = rise_vec | rep_set;
    // A set in the same cycle as a clear wins and is not an overrun.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    overrun_d = |(set_vec & pending_q & ~clr_vec);
  end

  assign kbus.key_valid = (state_q == S_VALID);
  assign kbus.key_code  = code_q;
  assign pending        = pending_q;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_key_sched.sv
// Bench for key_sched: directed scenarios plus a randomized phase, checked
// every cycle against a behavioural model of the keypad scheduler.
module tb_key_sched;
  localparam int N   = 5;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] pending;
  logic         overrun;

  key_sched_if #(.N_KEYS(N)) kbus ();

  key_sched #(
    .N_KEYS(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_in),
    .kbus   (kbus),
    .pending(pending),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_pend, m_prev;
  int         m_run[N];
  bit         m_ovr, m_offer;
  int         m_code, m_rr, m_held;

  // Observation counters
  int acc_cnt[N];
  int acc_q[$];
  int ovr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_pend = '0; m_prev = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_ovr = 0; m_offer = 0; m_code = 0; m_rr = 0; m_held = 0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit [N-1:0] set_v, clr_v, nlvl;
    bit         rdy;
    rdy   = kbus.key_ready;
    set_v = m_rise;
`ifdef KEY_REPEAT_EN
    if (m_lvl != m_prev || $countones(m_lvl) != 1) m_held = 0;
    else begin
      m_held++;
      if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) set_v |= m_lvl;
    end
    m_prev = m_lvl;
`endif
    clr_v = '0;
    if (m_offer && rdy) clr_v[m_code] = 1'b1;
    m_ovr = |(set_v & m_pend & ~clr_v);
    // Handshake / round-robin choice uses the pending set before this edge.
    if (m_offer) begin
      if (rdy) begin
        m_offer = 0;
        m_rr    = (m_code + 1) % N;
      end
    end else if (m_pend != '0) begin
      for (int k = 0; k < N; k++) begin
        if (!m_offer && m_pend[(m_rr + k) % N]) begin
          m_code  = (m_rr + k) % N;
          m_offer = 1;
        end
      end
    end
    m_pend = (m_pend & ~clr_v) | set_v;
    // Debouncers
    nlvl = m_lvl;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nlvl[i]  = m_s2[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
    m_rise = nlvl & ~m_lvl;
    m_lvl  = nlvl;
    m_s2   = m_s1;
    m_s1   = btn_in;
  endtask

  task automatic compare_all();
    chk("key_valid", {31'b0, kbus.key_valid}, {31'b0, m_offer});
    chk("key_code", 32'(kbus.key_code), 32'(m_code));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
  endtask

  task automatic tick();
    if (kbus.key_valid === 1'b1 && kbus.key_ready === 1'b1) begin
      acc_cnt[kbus.key_code]++;
      acc_q.push_back(int'(kbus.key_code));
    end
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (overrun === 1'b1) ovr_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    acc_q.delete();
    ovr_cnt = 0;
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0;
    btn_in = '0;
    kbus.key_ready = 1'b0;
    model_reset();
    clear_stats();
    ticks(2);
    chk("reset_valid", {31'b0, kbus.key_valid}, 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // Single clean press on key 2
    btn_in[2] = 1'b1;
    kbus.key_ready = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (kbus.key_valid === 1'b1 && lat < 0) lat = i;
    end
    chk("press_latency", 32'(lat), 32'd8);
    chk("press_events", 32'(acc_cnt[2]), 32'd1);
    chk("press_pending_after", 32'(pending), 32'd0);
    btn_in[2] = 1'b0;
    ticks(10);

    // Bounce rejection on key 1
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_in[1] = ~btn_in[1];
      tick();
      if (kbus.key_valid === 1'b1) seen = 1;
    end
    btn_in[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (kbus.key_valid === 1'b1) seen = 1;
    end
    chk("bounce_no_valid", {31'b0, seen}, 32'd0);
    chk("bounce_pending", 32'(pending), 32'd0);

    // Asynchronous reset while an event is offered
    kbus.key_ready = 1'b0;
    btn_in[1] = 1'b1;
    ticks(10);
    chk("pre_reset_valid", {31'b0, kbus.key_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'b0, kbus.key_valid}, 32'd0);
    chk("async_reset_pending", 32'(pending), 32'd0);
    chk("async_reset_code", 32'(kbus.key_code), 32'd0);
    model_reset();
    btn_in = '0;
    ticks(2);
    rst_n = 1'b1;
    ticks(10);

    // Round-robin over keys 0, 2, 4
    clear_stats();
    btn_in = 5'b10101;
    ticks(10);
    chk("rr_pending", 32'(pending), 32'h15);
    btn_in = '0;
    ticks(10);
    kbus.key_ready = 1'b1;
    ticks(8);
    chk("rr_count", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      chk("rr_first", 32'(acc_q[0]), 32'd0);
      chk("rr_second", 32'(acc_q[1]), 32'd2);
      chk("rr_third", 32'(acc_q[2]), 32'd4);
    end
    kbus.key_ready = 1'b0;
    btn_in = 5'b00101;
    ticks(12);
    chk("rr_wrap_valid", {31'b0, kbus.key_valid}, 32'd1);
    chk("rr_wrap_code", 32'(kbus.key_code), 32'd0);
    btn_in = '0;
    kbus.key_ready = 1'b1;
    ticks(10);

    // Overrun: two presses on key 3 while the core stalls
    kbus.key_ready = 1'b0;
    clear_stats();
    btn_in[3] = 1'b1;
    ticks(8);
    btn_in[3] = 1'b0;
    ticks(22);
    btn_in[3] = 1'b1;
    ticks(8);
    btn_in[3] = 1'b0;
    ticks(10);
    chk("overrun_pulses", 32'(ovr_cnt), 32'd1);
    kbus.key_ready = 1'b1;
    ticks(6);
    chk("overrun_events", 32'(acc_cnt[3]), 32'd1);

    // Press landing exactly in the accept cycle
    kbus.key_ready = 1'b0;
    btn_in[3] = 1'b1;
    ticks(10);
    btn_in[3] = 1'b0;
    ticks(8);
    btn_in[3] = 1'b1;
    ticks(6);
    kbus.key_ready = 1'b1;
    ovr_cnt = 0;
    tick();
    chk("accept_set_pending3", {31'b0, pending[3]}, 32'd1);
    chk("accept_set_no_overrun", {31'b0, overrun}, 32'd0);
    ticks(4);
    chk("accept_set_overrun_count", 32'(ovr_cnt), 32'd0);
    btn_in = '0;
    ticks(10);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        automatic int k = int'($urandom_range(0, N - 1));
        btn_in[k] = ~btn_in[k];
      end
      kbus.key_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    btn_in = '0;
    ticks(20);
    kbus.key_ready = 1'b1;
    ticks(20);

    // Held key 4, then a second key pressed while still held
    clear_stats();
    btn_in[4] = 1'b1;
    ticks(30);
    btn_in[0] = 1'b1;
    ticks(20);
    btn_in = '0;
    ticks(20);
`ifdef KEY_REPEAT_EN
    chk("hold_events_key4", 32'(acc_cnt[4]), 32'd3);
`else
    chk("hold_events_key4", 32'(acc_cnt[4]), 32'd1);
`endif
    chk("hold_events_key0", 32'(acc_cnt[0]), 32'd1);
    chk("final_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_sched.md
# key_sched

Keypad scheduler for the calculator front end. Takes N raw push-button lines and synchronizes, debounces and rising-edge-detects each one. Queues one pending press per key and hands presses one at a time to the calculator core over a valid/ready handshake, choosing among pending keys round-robin. It replaces per-button free-running edge detectors with one sequenced, arbitrated key-event source.

## Interface
Parameters:
- N_KEYS, 5, number of button inputs (≥2).
- DEB_CYCLES, 1000000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000, cycles held before the first auto-repeat. Used only with KEY_REPEAT_EN.
- REPEAT_RATE, 20000000, cycles between later auto-repeats. Used only with KEY_REPEAT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  N_KEYS  raw asynchronous button levels, active-high.
- key_ready  in  1  core accepts the current key event.
- key_valid  out  1  key event available.
- key_code  out  clog2(N_KEYS)  index of the key being offered.
- pending  out  N_KEYS  per-key queued-press flags.
- overrun  out  1  one-cycle pulse when a press arrives for a key already pending.

## Operation
- Per key: 2-flop synchronizer, then debouncer. The debounced level changes only after DEB_CYCLES consecutive synchronized samples differ from it. A mismatch-free sample, or the sample that completes the count, clears the counter.
- Rising edge of the debounced level, registered as db & ~db_q, sets pending[i]. Falling edges are ignored.
- Output FSM, two states:
  - IDLE: if pending is nonzero, grant the first set bit at or after rr_ptr, searching upward with wrap. Load key_code and go to VALID with key_valid=1.
  - VALID: hold key_valid and key_code stable. On key_ready=1, clear pending[key_code], set rr_ptr to key_code+1 (wrapping to 0 past N_KEYS-1), and go to IDLE.
- key_ready is ignored in IDLE.
- Simultaneous events:
  - A set and a clear of the same pending bit in one cycle: the set wins, pending stays 1, and overrun is not pulsed.
  - An edge on a key whose pending bit is already 1 and is not being cleared: overrun pulses and the press is merged.
  - Edges on several keys in one cycle: all set pending in that cycle.
- Reset, at any time: all synchronizer, debounce and pending state goes to 0. rr_ptr=0, FSM=IDLE. A button held across reset release produces one press after 2+DEB_CYCLES cycles.

## Timing
- Reset values: key_valid=0, key_code=0, pending=0, overrun=0.
- Latency from the btn_in transition to key_valid, with the FSM idle: 2 synchronizer cycles + DEB_CYCLES + 1 cycle (edge/pending) + 1 cycle (grant) = DEB_CYCLES+4 clocks.
- Throughput: at most one event every 2 cycles. The accept cycle is followed by an IDLE grant cycle.
- key_code never changes while key_valid=1.
- overrun is registered and asserts in the cycle after the offending edge is detected.
- Counter widths: clog2(DEB_CYCLES+1) per key; clog2(max(REPEAT_DELAY,REPEAT_RATE)+1) for the shared repeat counter.

## Configuration
- KEY_REPEAT_EN defined:
  - One shared repeat counter runs only while exactly one debounced level is high.
  - It restarts on any change of the debounced vector.
  - At REPEAT_DELAY, then every REPEAT_RATE cycles, it sets pending for the held key, with the same overrun rules as a press.
- KEY_REPEAT_EN undefined: no repeat counter is built, REPEAT_* parameters are unused, and a held key yields exactly one event.

## Structure
- Package calc_key_pkg:
  - Key index constants KEY_CENTER=0, KEY_UP=1, KEY_DOWN=2, KEY_LEFT=3, KEY_RIGHT=4.
  - FSM state typedef {S_IDLE, S_VALID}.
- Sub-module key_debounce: synchronizer + debounce counter + registered rising-edge output, instantiated N_KEYS times through generate.
- Arbiter, pending flags, FSM and repeat logic stay in key_sched.

## Test plan
Run the bench with DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
- Reset: assert rst_n=0 mid-run with key_valid=1 -> key_valid=0 and pending=0 immediately, with no clock.
- Single clean press: btn_in[2]=1 held, key_ready=1 -> key_valid high 8 cycles after the input change, key_code=2 for one cycle, pending=0 afterwards.
- Bounce rejection: toggle btn_in[1] every 2 cycles for 20 cycles, then hold low -> no key_valid, pending stays 0.
- Round-robin: pending=5'b10101 with key_ready held 0 for 10 cycles, then held 1 -> key_code sequence 0, 2, 4. Next grant after re-pressing keys 0 and 2 is 0 again (rr_ptr wrapped to 0).
- Overrun: press key 3 twice, 30 cycles apart, with key_ready=0 -> one overrun pulse, one event delivered once key_ready=1. A press landing in the accept cycle -> pending[3] stays 1, no overrun.
- KEY_REPEAT_EN: hold key 4 for 50 cycles, key_ready=1 -> events on key 4 at press, at +20 and at +28 cycles. A second key pressed concurrently stops further repeats.
